// File: rtl/ws2811_rx_decoder.sv
// ws2811_rx_decoder: WS2811 NRZ receiver, pulse-width bit decode into 24-bit GRB pixels with latch detection (optional frameLenOUT under WS2811_RX_FRAME_LEN_EN)
module ws2811_rx_decoder #(
   parameter int BIT_THRESHOLD_CYCLES = 22,
   parameter int MIN_HIGH_CYCLES = 5,
   parameter int MAX_HIGH_CYCLES = 50,
   parameter int RESET_CYCLES = 2500,
   parameter int MAX_PIXELS = 256
) (
   input  logic clkIN,
   input  logic resetIN,
   input  logic dataIN,
   output logic [23:0] pixelOUT,
   output logic pixelValidOUT,
   output logic [$clog2(MAX_PIXELS)-1:0] pixelIndexOUT,
   output logic frameDoneOUT,
   output logic errorOUT,
`ifdef WS2811_RX_FRAME_LEN_EN
   output logic busyOUT,
   output logic [$clog2(MAX_PIXELS+1)-1:0] frameLenOUT
`else
   output logic busyOUT
`endif
);
   localparam int CW = $clog2(RESET_CYCLES+1);
   localparam int IW = $clog2(MAX_PIXELS);
   localparam int PW = $clog2(MAX_PIXELS+1);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] RST_C = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] RST_M1 = CW'(RESET_CYCLES-1);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_HIGH_CYCLES);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_HIGH_CYCLES);
   localparam logic [CW-1:0] THR_C = CW'(BIT_THRESHOLD_CYCLES);
   localparam logic [PW-1:0] PMAX = PW'(MAX_PIXELS);
   typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;
   state_t state_q;
   logic s1_q, s2_q, h_q, rise_q, fall_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0] sh_q, pixel_q, word_d;
   logic [4:0] bits_q;
   logic [PW-1:0] pix_q, len_q;
   logic [IW-1:0] idx_q;
   logic valid_q, done_q, err_q, busy_q, bit_d;
   assign cnt_d = (cnt_q == RST_C) ? cnt_q : cnt_q + ONE;
   assign bit_d = cnt_q >= THR_C;
   assign word_d = {sh_q[22:0], bit_d};
   assign pixelOUT = pixel_q;
   assign pixelValidOUT = valid_q;
   assign pixelIndexOUT = idx_q;
   assign frameDoneOUT = done_q;
   assign errorOUT = err_q;
   assign busyOUT = busy_q;
`ifdef WS2811_RX_FRAME_LEN_EN
   assign frameLenOUT = len_q;
`else
   logic unused_len;
   assign unused_len = ^len_q;
`endif
   // Two-stage synchronizer, history stage, and registered edge flags aligned with h_q
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         h_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q <= dataIN;
         s2_q <= s1_q;
         h_q <= s2_q;
         rise_q <= s2_q & ~h_q;
         fall_q <= ~s2_q & h_q;
      end
   end
   // Pulse-width FSM: measures the line, assembles pixels and drives registered strobes
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         state_q <= SYNC;
         cnt_q <= '0;
         sh_q <= '0;
         bits_q <= '0;
         pix_q <= '0;
         pixel_q <= '0;
         idx_q <= '0;
         len_q <= '0;
         valid_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            SYNC: begin
               state_q <= (!h_q && cnt_d == RST_C) ? LOW : SYNC;
               cnt_q <= (h_q || cnt_d == RST_C) ? '0 : cnt_d;
            end
            LOW: begin
               if (rise_q) begin
                  state_q <= HIGH;
                  cnt_q <= ONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (busy_q && cnt_q == RST_M1) begin
                     done_q <= 1'b1;
                     err_q <= bits_q != 5'd0;
                     len_q <= pix_q;
                     bits_q <= '0;
                     pix_q <= '0;
                     busy_q <= 1'b0;
                  end
               end
            end
            HIGH: begin
               if (fall_q && cnt_q < MIN_C) begin
                  err_q <= 1'b1;
                  bits_q <= '0;
                  state_q <= SYNC;
                  cnt_q <= '0;
               end else if (fall_q) begin
                  sh_q <= word_d;
                  busy_q <= 1'b1;
                  state_q <= LOW;
                  cnt_q <= ONE;
                  bits_q <= (bits_q == 5'd23) ? 5'd0 : bits_q + 5'd1;
                  if (bits_q == 5'd23 && pix_q != PMAX) begin
                     valid_q <= 1'b1;
                     pixel_q <= word_d;
                     idx_q <= pix_q[IW-1:0];
                     pix_q <= pix_q + PW'(1);
                  end
               end else if (cnt_d > MAX_C) begin
                  err_q <= 1'b1;
                  bits_q <= '0;
                  state_q <= SYNC;
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2811_rx_decoder.sv
// tb_ws2811_rx_decoder: directed scoreboard bench for ws2811_rx_decoder
module tb_ws2811_rx_decoder;
   typedef struct {logic [23:0] w; int idx; int at;} exp_t;
   logic clk = 1'b0, resetIN = 1'b1, dataIN = 1'b0;
   logic [23:0] pixelOUT;
   logic pixelValidOUT, frameDoneOUT, errorOUT, busyOUT;
   logic [7:0] pixelIndexOUT;
`ifdef WS2811_RX_FRAME_LEN_EN
   logic [8:0] frameLenOUT;
`endif
   exp_t q[$];
   int checks = 0, failures = 0, pe = 0, last_fall = 0;
   int done_n = 0, err_n = 0, done_pe = 0, err_pe = 0, d0, e0, r;
   bit arm = 1'b0;
   logic [23:0] arm_w;
   int arm_idx;
   ws2811_rx_decoder dut (
      .clkIN(clk), .resetIN(resetIN), .dataIN(dataIN),
      .pixelOUT(pixelOUT), .pixelValidOUT(pixelValidOUT), .pixelIndexOUT(pixelIndexOUT),
      .frameDoneOUT(frameDoneOUT), .errorOUT(errorOUT),
`ifdef WS2811_RX_FRAME_LEN_EN
      .busyOUT(busyOUT), .frameLenOUT(frameLenOUT)
`else
      .busyOUT(busyOUT)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) pe++;
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (pixelValidOUT) begin
         chk("valid_expected", int'(q.size() > 0), 1);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pixel_word", int'(pixelOUT), int'(e.w));
            chk("pixel_index", int'(pixelIndexOUT), e.idx);
            chk("pixel_latency", pe, e.at);
         end
      end
      if (frameDoneOUT) begin done_n++; done_pe = pe; end
      if (errorOUT) begin err_n++; err_pe = pe; end
   end
   task automatic low(input int n);
      dataIN = 1'b0;
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse(input int h, input int l);
      dataIN = 1'b1;
      repeat (h) @(negedge clk);
      dataIN = 1'b0;
      last_fall = pe;
      if (arm) q.push_back('{arm_w, arm_idx, pe + 4});
      arm = 1'b0;
      repeat (l) @(negedge clk);
   endtask
   task automatic send(input logic [23:0] w, input int n, input int idx);
      for (int i = 23; i >= 24 - n; i--) begin
         if (i == 0 && idx >= 0) begin arm = 1'b1; arm_w = w; arm_idx = idx; end
         pulse(w[i] ? 30 : 12, w[i] ? 32 : 50);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_pixel"}, int'(pixelOUT), 0);
      chk({tag, "_valid"}, int'(pixelValidOUT), 0);
      chk({tag, "_index"}, int'(pixelIndexOUT), 0);
      chk({tag, "_done"}, int'(frameDoneOUT), 0);
      chk({tag, "_error"}, int'(errorOUT), 0);
      chk({tag, "_busy"}, int'(busyOUT), 0);
   endtask
   initial begin
      #1000000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) @(negedge clk);
      chk_idle("reset");
      resetIN = 1'b0;
      low(2600);
      d0 = done_n; e0 = err_n;
      send(24'hFF0080, 24, 0);
      chk("busy_during_frame", int'(busyOUT), 1);
      low(2600);
      chk("single_done", done_n - d0, 1);
      chk("single_done_gap", int'(done_pe - last_fall >= 2500 && done_pe - last_fall <= 2506), 1);
      chk("single_no_error", err_n - e0, 0);
      chk("single_drained", q.size(), 0);
      chk("single_busy_cleared", int'(busyOUT), 0);
`ifdef WS2811_RX_FRAME_LEN_EN
      chk("single_frame_len", int'(frameLenOUT), 1);
`endif
      d0 = done_n;
      send(24'h123456, 24, 0);
      send(24'hABCDEF, 24, 1);
      send(24'h000001, 24, 2);
      low(2600);
      chk("three_done", done_n - d0, 1);
      chk("three_no_error", err_n - e0, 0);
      chk("three_drained", q.size(), 0);
`ifdef WS2811_RX_FRAME_LEN_EN
      chk("three_frame_len", int'(frameLenOUT), 3);
`endif
      d0 = done_n;
      send(24'h5A5A5A, 22, -1);
      pulse(21, 40);
      arm = 1'b1; arm_w = 24'h5A5A59; arm_idx = 0;
      pulse(22, 40);
      low(2600);
      chk("threshold_done", done_n - d0, 1);
      chk("threshold_drained", q.size(), 0);
      pulse(4, 40);
      chk("glitch_error", err_n - e0, 1);
      send(24'hFFFFFF, 24, -1);
      chk("sync_ignores_pixel", q.size(), 0);
      chk("sync_no_more_errors", err_n - e0, 1);
      low(2600);
      send(24'h00FF00, 24, 0);
      low(2600);
      chk("after_sync_done", done_n - d0, 2);
      chk("after_sync_drained", q.size(), 0);
      d0 = done_n; e0 = err_n;
      r = pe;
      dataIN = 1'b1;
      repeat (60) @(negedge clk);
      low(2700);
      chk("stuck_error", err_n - e0, 1);
      chk("stuck_error_delay", int'(err_pe - r >= 52 && err_pe - r <= 56), 1);
      chk("stuck_no_done", done_n - d0, 0);
      d0 = done_n; e0 = err_n;
      send(24'hC3C3C3, 10, -1);
      chk("partial_busy", int'(busyOUT), 1);
      low(2600);
      chk("partial_done", done_n - d0, 1);
      chk("partial_error", err_n - e0, 1);
      chk("partial_same_cycle", done_pe, err_pe);
      chk("partial_busy_fall", int'(busyOUT), 0);
      chk("partial_drained", q.size(), 0);
      d0 = done_n; e0 = err_n;
      send(24'h0F0F0F, 12, -1);
      resetIN = 1'b1;
      @(negedge clk);
      chk_idle("midframe_reset");
      resetIN = 1'b0;
      low(2600);
      send(24'hC0FFEE, 24, 0);
      low(2600);
      chk("post_reset_done", done_n - d0, 1);
      chk("post_reset_no_error", err_n - e0, 0);
      chk("post_reset_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
